// File: rtl/byte_data_memory_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes, FSM states,
// and the byte-lane mask helper used by both the store path and the load aligner.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int MAX_READ_LATENCY = 8;
  localparam int CNT_WIDTH        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } mem_state_e;

  // Byte lanes touched by an access; empty for the reserved size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b0001 << offset;
      SIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: lane_mask = 4'b1111;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic access_error(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: access_error = 1'b0;
      SIZE_HALF: access_error = offset[0];
      SIZE_WORD: access_error = (offset != 2'b00);
      default:   access_error = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_data_memory_load_align.sv
// Combinational load aligner: masks never-written bytes to zero, selects the
// addressed lanes, extends to 32 bits and reports whether any lane was unwritten.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [3:0]  written,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result,
  output logic        uninit
);

  logic [31:0] masked_s;
  logic [31:0] shifted_s;

  // Zero unwritten bytes, then bring the addressed lanes down to bit 0.
  always_comb begin
    masked_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      masked_s[8*k +: 8] = written[k] ? raw_word[8*k +: 8] : 8'h00;
    end
    shifted_s = masked_s >> {offset, 3'b000};
  end

  // Size-dependent extension and uninit detection.
  always_comb begin
    result = 32'h0000_0000;
    uninit = |(lane_mask(size, offset) & ~written);
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
      SIZE_HALF: result = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
      SIZE_WORD: result = masked_s;
      default:   result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed data memory with sized loads/stores, per-byte written flags,
// configurable read latency and a single-outstanding request/response handshake.
module byte_data_memory
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS  = 256,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_WIDTH   = $clog2(DEPTH_WORDS) + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  resp_uninit
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  mem_state_e           state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic                 req_ready_r, resp_valid_r, resp_error_r, resp_uninit_r;
  logic [31:0]          resp_rdata_r;

  logic                 accept_s, consume_s, err_s, store_s, load_uninit_s;
  logic [IDX_WIDTH-1:0] idx_s;
  logic [1:0]           offset_s;
  logic [3:0]           mask_s;
  logic [31:0]          wword_s, raw_word_s, load_data_s;
  logic [3:0]           written_r [DEPTH_WORDS];

  assign idx_s     = req_addr[ADDR_WIDTH-1:2];
  assign offset_s  = req_addr[1:0];
  assign mask_s    = lane_mask(req_size, offset_s);
  assign err_s     = access_error(req_size, offset_s);
  assign accept_s  = req_valid && req_ready_r;
  assign consume_s = resp_valid_r && resp_ready;
  // rst_n gate keeps requests presented during reset from touching the array.
  assign store_s   = rst_n && accept_s && req_write && !err_s;

  // Replicate narrow store data so every lane sees its bytes; the mask picks lanes.
  always_comb begin
    wword_s = 32'h0000_0000;
    case (req_size)
      SIZE_BYTE: wword_s = {4{req_wdata[7:0]}};
      SIZE_HALF: wword_s = {2{req_wdata[15:0]}};
      SIZE_WORD: wword_s = req_wdata;
      default:   wword_s = 32'h0000_0000;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] lane_r [DEPTH_WORDS];

    // Byte-lane storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
      if (store_s && mask_s[k]) begin
        lane_r[idx_s] <= wword_s[8*k +: 8];
      end
    end

    assign raw_word_s[8*k +: 8] = lane_r[idx_s];
  end

  // Per-byte written flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        written_r[i] <= 4'b0000;
      end
    end else if (store_s) begin
      written_r[idx_s] <= written_r[idx_s] | mask_s;
    end
  end

  mem_load_align u_align (
    .raw_word    (raw_word_s),
    .written     (written_r[idx_s]),
    .offset      (offset_s),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .result      (load_data_s),
    .uninit      (load_uninit_s)
  );

  // FSM next-state and latency counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (READ_LATENCY == 1) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_WIDTH'(READ_LATENCY - 1);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_r - CNT_WIDTH'(1);
        if (cnt_r == CNT_WIDTH'(1)) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, handshake flags and the held response; payload is captured at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      req_ready_r   <= 1'b1;
      resp_valid_r  <= 1'b0;
      resp_rdata_r  <= 32'h0000_0000;
      resp_error_r  <= 1'b0;
      resp_uninit_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      resp_valid_r <= (state_nxt_s == ST_RESP);
      if (accept_s) begin
        resp_error_r  <= err_s;
        resp_rdata_r  <= (err_s || req_write) ? 32'h0000_0000 : load_data_s;
        resp_uninit_r <= !err_s && !req_write && load_uninit_s;
      end else if (consume_s) begin
        resp_error_r  <= 1'b0;
        resp_rdata_r  <= 32'h0000_0000;
        resp_uninit_r <= 1'b0;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = resp_rdata_r;
  assign resp_error  = resp_error_r;
  assign resp_uninit = resp_uninit_r;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed, table-driven bench for byte_data_memory at READ_LATENCY=3, plus
// hand-written backpressure and mid-operation reset sequences.
module tb_byte_data_memory;
  import mem_pkg::*;

  localparam int LAT = 3;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready, resp_valid, resp_error, resp_uninit;
  logic [31:0]   resp_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic          w;
    logic [1:0]    sz;
    logic          u;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rd;
    logic          exp_er;
    logic          exp_un;
  } vec_t;

  vec_t vq[$];

  byte_data_memory #(.DEPTH_WORDS(256), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .resp_uninit(resp_uninit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic w, input logic [1:0] sz, input logic u,
                     input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] rd,
                     input logic er, input logic un);
    vec_t v;
    v.name = n; v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wdata = d;
    v.exp_rd = rd; v.exp_er = er; v.exp_un = un;
    vq.push_back(v);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
  endtask

  // Counts cycles from the acceptance edge until resp_valid is seen (bounded).
  task automatic wait_resp(input string name, output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) check({name, "_timeout"}, 32'(resp_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({v.name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    drive(v.w, v.sz, v.u, v.addr, v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(v.name, lat);
    check({v.name, "_latency"}, 32'(lat), 32'(LAT));
    check({v.name, "_rdata"}, resp_rdata, v.exp_rd);
    check({v.name, "_error"}, 32'(resp_error), 32'(v.exp_er));
    check({v.name, "_uninit"}, 32'(resp_uninit), 32'(v.exp_un));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b0;

    add("sw_10",     1'b1, SIZE_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    add("lw_10",     1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    add("sw_20",     1'b1, SIZE_WORD, 1'b0, 10'h020, 32'h80FF7F01, 32'h00000000, 1'b0, 1'b0);
    add("lb_23",     1'b0, SIZE_BYTE, 1'b0, 10'h023, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
    add("lbu_23",    1'b0, SIZE_BYTE, 1'b1, 10'h023, 32'h0,        32'h00000080, 1'b0, 1'b0);
    add("lh_22",     1'b0, SIZE_HALF, 1'b0, 10'h022, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0);
    add("lhu_20",    1'b0, SIZE_HALF, 1'b1, 10'h020, 32'h0,        32'h00007F01, 1'b0, 1'b0);
    add("sb_31",     1'b1, SIZE_BYTE, 1'b0, 10'h031, 32'h000000AB, 32'h00000000, 1'b0, 1'b0);
    add("lw_30_part",1'b0, SIZE_WORD, 1'b0, 10'h030, 32'h0,        32'h0000AB00, 1'b0, 1'b1);
    add("sw_30",     1'b1, SIZE_WORD, 1'b0, 10'h030, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    add("lw_30_full",1'b0, SIZE_WORD, 1'b0, 10'h030, 32'h0,        32'h00000000, 1'b0, 1'b0);
    add("lw_42_mis", 1'b0, SIZE_WORD, 1'b0, 10'h042, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add("sh_41_mis", 1'b1, SIZE_HALF, 1'b0, 10'h041, 32'h00001234, 32'h00000000, 1'b1, 1'b0);
    add("lhu_40",    1'b0, SIZE_HALF, 1'b1, 10'h040, 32'h0,        32'h00000000, 1'b0, 1'b1);
    add("ld_rsvd",   1'b0, 2'b11,     1'b0, 10'h050, 32'h0,        32'h00000000, 1'b1, 1'b0);
    add("st_rsvd",   1'b1, 2'b11,     1'b0, 10'h054, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    add("lw_54",     1'b0, SIZE_WORD, 1'b0, 10'h054, 32'h0,        32'h00000000, 1'b0, 1'b1);
    add("lb_11",     1'b0, SIZE_BYTE, 1'b0, 10'h011, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0);
    add("lhu_12",    1'b0, SIZE_HALF, 1'b1, 10'h012, 32'h0,        32'h0000DEAD, 1'b0, 1'b0);
    add("sh_12",     1'b1, SIZE_HALF, 1'b0, 10'h012, 32'hFFFF1234, 32'h00000000, 1'b0, 1'b0);
    add("lw_10_new", 1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0,        32'h1234BEEF, 1'b0, 1'b0);
    add("lh_10",     1'b0, SIZE_HALF, 1'b0, 10'h010, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0);
    add("lw_13_mis", 1'b0, SIZE_WORD, 1'b0, 10'h013, 32'h0,        32'h00000000, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", 32'(resp_error), 32'd0);
    check("rst_uninit", 32'(resp_uninit), 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i]);

    // Backpressure: hold the response 5 cycles while a second request waits.
    @(negedge clk);
    drive(1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0);
    @(negedge clk);
    req_addr = 10'h020;
    wait_resp("bp_first", lat);
    check("bp_first_latency", 32'(lat), 32'(LAT));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_rdata", resp_rdata, 32'h1234BEEF);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_after_ready", 32'(req_ready), 32'd1);
    check("bp_after_valid", 32'(resp_valid), 32'd0);
    check("bp_after_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    wait_resp("bp_second", lat);
    check("bp_second_latency", 32'(lat), 32'(LAT));
    check("bp_second_rdata", resp_rdata, 32'h80FF7F01);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during WAIT; a store presented in reset must not be accepted.
    @(negedge clk);
    drive(1'b0, SIZE_WORD, 1'b0, 10'h020, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mrst_in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    drive(1'b1, SIZE_WORD, 1'b0, 10'h060, 32'h55555555);
    repeat (2) begin
      @(negedge clk);
      check("mrst_valid_in_reset", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    check("mrst_req_ready", 32'(req_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("mrst_no_resp", 32'(resp_valid), 32'd0);
    end
    vq.delete();
    add("mrst_lw_10", 1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0, 32'h00000000, 1'b0, 1'b1);
    add("mrst_lw_60", 1'b0, SIZE_WORD, 1'b0, 10'h060, 32'h0, 32'h00000000, 1'b0, 1'b1);
    foreach (vq[i]) run_vec(vq[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Parametrised data memory for the MIPS datapath: byte-addressed, byte/halfword/word loads and stores with sign or zero extension, a configurable read latency, and a request/response handshake. It sits between the MEM stage and the storage array. Per-byte written-flags are cleared on reset, and reads of never-written bytes are flagged rather than returning undefined data. Misaligned or malformed accesses are reported as errors instead of corrupting memory.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 4
- READ_LATENCY, 1, cycles from request acceptance to response; range 1..8
- ADDR_WIDTH (localparam), $clog2(DEPTH_WORDS)+2, byte-address width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for words and stores
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data; byte/half stores use the low bits
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  misaligned access or reserved size
- resp_uninit  out  1  load touched at least one byte not written since reset

## Operation
- Little-endian lanes: byte at addr[1:0]=k occupies word bits 8k+7:8k.
- Word index is req_addr[ADDR_WIDTH-1:2]. No out-of-range addresses exist.
- Error conditions: half with addr[0]=1, word with addr[1:0]!=0, size 11. On error there is no write and no flag update; response carries rdata=0, error=1, uninit=0.
- Store, on the acceptance edge: write only the addressed byte lanes and set their written-flags.
- Load, on the acceptance edge: capture the addressed bytes. Bytes never written since reset read as 0x00 and set uninit. Extend to 32 bits per req_unsigned. Result is held until the response is consumed.
- One outstanding request at a time. Every accepted request yields exactly one response.
- FSM states:
  - IDLE: req_ready=1. On acceptance, go to RESP if READ_LATENCY=1, otherwise go to WAIT with cnt=READ_LATENCY-1.
  - WAIT: decrement cnt each edge; go to RESP on the edge where cnt=1.
  - RESP: resp_valid=1. Go to IDLE on an edge with resp_ready=1.
- Reset (rst_n low at an edge), including mid-operation:
  - State goes to IDLE, cnt=0.
  - All written-flags are cleared; array contents are untouched.
  - Any pending response is discarded.
  - Requests presented while rst_n is low are not accepted, and the array is not written.

## Timing
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_error=0, resp_uninit=0.
- Acceptance occurs at edge E0 when req_valid&&req_ready. resp_valid rises after edge E0+READ_LATENCY-1, i.e. READ_LATENCY cycles after the acceptance cycle.
- Response fields are stable while resp_valid=1. After the consuming edge they return to 0 and req_ready returns to 1.
- resp_ready high before resp_valid has no effect.
- Peak throughput is one request per READ_LATENCY+1 cycles.
- Store then load to the same address returns the new data, since the store commits at its acceptance edge.

## Structure
- Package mem_pkg holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), the FSM state enum, and the maximum READ_LATENCY constant.
- Sub-module mem_load_align is combinational. From the raw word, flags, offset, size and unsigned bit it produces the extended result and uninit. It is instantiated once.
- Storage: 4 byte-lane arrays of DEPTH_WORDS×8, plus DEPTH_WORDS×4 written-flags in flops (resettable).

## Test plan
- Word store then load: store 0xDEADBEEF @0x10, then load word @0x10 at READ_LATENCY=3. Required: rdata=0xDEADBEEF, error=0, uninit=0, and resp_valid first high 3 cycles after the acceptance cycle.
- Byte/half extension: store word 0x80FF7F01 @0x20, then load:
  - lb @0x23 → 0xFFFFFF80
  - lbu @0x23 → 0x00000080
  - lh @0x22 → 0xFFFF80FF
  - lhu @0x20 → 0x00007F01
- Partial store and uninit:
  - After reset, sb 0xAB @0x31, then lw @0x30 → rdata=0x0000AB00, uninit=1.
  - Then sw 0 @0x30 and lw @0x30 → uninit=0.
- Errors:
  - lw @0x42 → error=1, rdata=0.
  - sh 0x1234 @0x41 → error=1; a subsequent lhu @0x40 shows unchanged memory and uninit=1.
  - size=11 → error=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP. Required: response held stable, req_ready=0, and a second req_valid is not accepted until one cycle after resp_ready.
- Reset mid-operation: assert rst_n=0 during WAIT. Required: resp_valid never rises for that request, req_ready=1 after reset, and a previously written address reads uninit=1, rdata=0.
